// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding, frame
//                geometry, default bit period and the parity helper used by
//                both the transmit and receive chains.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame geometry: start + 8 data + parity + stop.
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

  // 50 MHz system clock divided down to 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Raw state codes, kept as plain constants so older blocks that carry the
  // state in a bare vector can still decode it.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } uart_state_e;

  // Even parity: the returned bit makes the total count of ones over the
  // data byte and the parity bit even. The rx side checks with this same
  // function so both ends always agree on the sense.
  function automatic logic parity8(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled
//                and flags the last cycle of each bit period with a
//                one-cycle tick. Synchronous clear restarts a period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // A single-cycle bit period cannot be represented; the counter needs
  // at least one bit of width.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST_COUNT);

  // The tick is only meaningful while the counter is actually running.
  assign tick = enable && w_at_last;

  // Period counter: wraps to zero on the terminal count, never beyond it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Latches a byte supplied as two nibbles,
//                computes even parity and shifts out an 11-bit frame
//                (start, 8 data LSB-first, parity, stop) on an idle-high
//                line. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] low_nibble,
  input  logic [3:0] high_nibble,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e            r_state;
  uart_state_e            w_state_next;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_parity;
  logic [BIT_IDX_W-1:0]   r_bit_idx;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;

  logic [DATA_BITS-1:0]   w_data_in;
  logic                   w_accept;
  logic                   w_bit_end;
  logic                   w_last_bit;
  logic                   w_baud_en;

  assign w_data_in  = {high_nibble, low_nibble};

  // Requests are only honoured from IDLE; anything arriving mid-frame is
  // dropped rather than queued.
  assign w_accept   = (r_state == ST_IDLE) && tx_start;
  assign w_last_bit = (r_bit_idx == LAST_BIT_IDX);
  assign w_baud_en  = (r_state != ST_IDLE);

  // The bit period restarts at acceptance so the start bit gets a full
  // CLKS_PER_BIT cycles regardless of any earlier counter history.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_accept),
    .enable (w_baud_en),
    .tick   (w_bit_end)
  );

  // Next-state decode: every transition out of a busy state waits for the
  // end of the current bit period.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && w_last_bit) begin
          w_state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Byte and parity capture at acceptance; held stable for the whole frame
  // so input changes mid-frame cannot corrupt it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_data   <= w_data_in;
      r_parity <= parity8(w_data_in);
    end
  end

  // Data bit index: zeroed on entry to DATA, advanced per bit period,
  // and never stepped past the last data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx <= '0;
    end else if (r_state == ST_DATA) begin
      if (w_bit_end && !w_last_bit) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end else begin
      r_bit_idx <= '0;
    end
  end

  // Serial line register: loaded one cycle ahead with the level of the bit
  // that the upcoming period will carry, so tx changes exactly on the
  // edge where the state advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_tx <= tx_start ? 1'b0 : 1'b1;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx <= r_data[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (w_last_bit) begin
              r_tx <= r_parity;
            end else begin
              r_tx <= r_data[r_bit_idx + 1'b1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx <= 1'b1;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
        end
        default: begin
          r_tx <= 1'b1;
        end
      endcase
    end
  end

  // Busy/done flags: busy spans acceptance to the end of the stop bit;
  // done pulses for the single cycle after the stop bit completes. A reset
  // mid-frame clears busy without ever raising done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if ((r_state == ST_STOP) && w_bit_end) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule : uart_tx
`default_nettype wire
